// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: state encoding, MODE codes, LFSR tap masks and fixed words for pattern_gen.
// Used by pattern_gen and prbs_step64; the optional error injection is gated by PATTERN_GEN_ERR_INJ_EN.
package pattern_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_PRBS7  = 2'd0;
   localparam logic [1:0] MODE_PRBS31 = 2'd1;
   localparam logic [1:0] MODE_COUNT  = 2'd2;
   localparam logic [1:0] MODE_ALT    = 2'd3;

   // Feedback taps: x^7+x^6+1 uses state bits 6,5; x^31+x^28+1 uses bits 30,27.
   localparam logic [30:0] TAPS_PRBS7  = 31'h0000_0060;
   localparam logic [30:0] TAPS_PRBS31 = 31'h4800_0000;
   localparam logic [30:0] MASK_PRBS7  = 31'h0000_007F;
   localparam logic [30:0] MASK_PRBS31 = 31'h7FFF_FFFF;

   localparam logic [63:0] ALT_FIRST  = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] ALT_SECOND = 64'h5555_5555_5555_5555;

   function automatic logic [30:0] seed_for(input logic [30:0] seed, input logic [1:0] mode);
      logic [30:0] mask;
      logic [30:0] v;
      mask = (mode == MODE_PRBS7) ? MASK_PRBS7 : MASK_PRBS31;
      v    = seed & mask;
      if (v == '0) v = mask;
      return v;
   endfunction

endpackage

// File: rtl/prbs_step64.sv
// prbs_step64: combinational 64-bit advance of a Fibonacci LFSR (PRBS7 or PRBS31).
// The earliest serial bit lands in word[63]; next_state continues the sequence.
module prbs_step64
   import pattern_gen_pkg::*;
(
   input  logic        prbs7,
   input  logic [30:0] state,
   output logic [30:0] next_state,
   output logic [63:0] word
);

   logic [30:0] taps;
   logic [30:0] mask;
   logic [30:0] s;
   logic        fb;

   // Unrolled serial shifting; bit 0 of the state holds the newest bit.
   always_comb begin
      taps = prbs7 ? TAPS_PRBS7 : TAPS_PRBS31;
      mask = prbs7 ? MASK_PRBS7 : MASK_PRBS31;
      s    = state & mask;
      fb   = 1'b0;
      word = '0;
      for (int i = 63; i >= 0; i--) begin
         fb      = ^(s & taps);
         word[i] = fb;
         s       = {s[29:0], fb} & mask;
      end
      next_state = s;
   end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: SYNC preamble followed by PRBS7/PRBS31/counter/alternating test words.
// Define PATTERN_GEN_ERR_INJ_EN to enable single-bit error injection on INJ_REQ.
module pattern_gen
   import pattern_gen_pkg::*;
#(
   parameter logic [30:0] SEED      = 31'h7FFF_FFFF,
   parameter logic [63:0] SYNC_WORD = 64'hFFFF_FFFF_0000_0000
)(
   input  logic        CLKF,
   input  logic        RSTF,
   input  logic        START,
   input  logic        STOP,
   input  logic [1:0]  MODE,
   input  logic [7:0]  SYNC_LEN,
   input  logic        INJ_REQ,
   output logic [63:0] DOUT,
   output logic        DOUT_VLD,
   output logic        BUSY,
   output logic        INJ_ACK,
   output logic [31:0] WORD_CNT
);

   state_t      state;
   logic [1:0]  mode_q;
   logic [7:0]  sync_left;
   logic [30:0] lfsr;
   logic [63:0] count;
   logic        alt_odd;

   logic [1:0]  src_mode;
   logic [30:0] src_lfsr;
   logic [63:0] src_count;
   logic        src_alt;
   logic        src_prbs7;
   logic [30:0] lfsr_next;
   logic [63:0] prbs_word;
   logic [63:0] pattern_word;
   logic [63:0] run_word;
   logic [31:0] cnt_sat;
   logic        inj_fire;

   // From IDLE the emitted word is the first of a fresh run, so take seed/zero state directly.
   always_comb begin
      if (state == IDLE) begin
         src_mode  = MODE;
         src_lfsr  = seed_for(SEED, MODE);
         src_count = '0;
         src_alt   = 1'b0;
      end else begin
         src_mode  = mode_q;
         src_lfsr  = lfsr;
         src_count = count;
         src_alt   = alt_odd;
      end
      src_prbs7 = (src_mode == MODE_PRBS7);
      case (src_mode)
         MODE_PRBS7, MODE_PRBS31: pattern_word = prbs_word;
         MODE_COUNT:              pattern_word = src_count;
         default:                 pattern_word = src_alt ? ALT_SECOND : ALT_FIRST;
      endcase
      run_word = pattern_word ^ {63'd0, inj_fire};
      cnt_sat  = (WORD_CNT == 32'hFFFF_FFFF) ? WORD_CNT : WORD_CNT + 32'd1;
   end

   prbs_step64 u_step (
      .prbs7      (src_prbs7),
      .state      (src_lfsr),
      .next_state (lfsr_next),
      .word       (prbs_word)
   );

`ifdef PATTERN_GEN_ERR_INJ_EN
   logic inj_req_q;

   // A request is its rising edge, so a held INJ_REQ merges into a single corrupted word.
   always_ff @(posedge CLKF or posedge RSTF) begin
      if (RSTF) inj_req_q <= 1'b0;
      else      inj_req_q <= INJ_REQ;
   end

   assign inj_fire = (state == RUN) && INJ_REQ && !inj_req_q;
`else
   logic unused_inj_req;
   assign unused_inj_req = INJ_REQ;
   assign inj_fire       = 1'b0;
`endif

   always_ff @(posedge CLKF or posedge RSTF) begin
      if (RSTF) begin
         state     <= IDLE;
         mode_q    <= MODE_PRBS7;
         sync_left <= '0;
         lfsr      <= seed_for(SEED, MODE_PRBS31);
         count     <= '0;
         alt_odd   <= 1'b0;
         DOUT      <= '0;
         DOUT_VLD  <= 1'b0;
         BUSY      <= 1'b0;
         INJ_ACK   <= 1'b0;
         WORD_CNT  <= '0;
      end else if (state != IDLE && STOP) begin
         state    <= IDLE;
         DOUT     <= '0;
         DOUT_VLD <= 1'b0;
         BUSY     <= 1'b0;
         INJ_ACK  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START && !STOP) begin
                  mode_q   <= MODE;
                  BUSY     <= 1'b1;
                  DOUT_VLD <= 1'b1;
                  INJ_ACK  <= 1'b0;
                  if (SYNC_LEN == 8'd0) begin
                     state    <= RUN;
                     DOUT     <= run_word;
                     lfsr     <= lfsr_next;
                     count    <= src_count + 64'd1;
                     alt_odd  <= ~src_alt;
                     WORD_CNT <= 32'd1;
                  end else begin
                     state     <= (SYNC_LEN == 8'd1) ? RUN : SYNC;
                     sync_left <= SYNC_LEN - 8'd1;
                     DOUT      <= SYNC_WORD;
                     lfsr      <= src_lfsr;
                     count     <= '0;
                     alt_odd   <= 1'b0;
                     WORD_CNT  <= '0;
                  end
               end
            end
            SYNC: begin
               DOUT      <= SYNC_WORD;
               INJ_ACK   <= 1'b0;
               sync_left <= sync_left - 8'd1;
               if (sync_left == 8'd1) state <= RUN;
            end
            RUN: begin
               DOUT     <= run_word;
               INJ_ACK  <= inj_fire;
               lfsr     <= lfsr_next;
               count    <= src_count + 64'd1;
               alt_odd  <= ~src_alt;
               WORD_CNT <= cnt_sat;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
